// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: scaling algorithm codes and the zoom engine state encoding.
package coproc_pkg;

  typedef enum logic [1:0] {
    ALG_REPLICATE = 2'd0,
    ALG_DECIMATE  = 2'd1,
    ALG_AVERAGE   = 2'd2,
    ALG_COPY      = 2'd3
  } alg_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int IMG_W_BITS = 10;
  localparam int IMG_H_BITS = 9;

endpackage

// File: rtl/zoom_addr_gen.sv
// Walks output pixels in raster order (and the source block inside each pixel for averaging),
// producing the source read address, the linear destination address and end-of-block/end-of-image flags.
module zoom_addr_gen
  import coproc_pkg::*;
#(
  parameter int SRC_W      = 160,
  parameter int SRC_ADDR_W = 15,
  parameter int DST_ADDR_W = 17,
  parameter int MAX_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [1:0]            alg,
  input  logic [1:0]            k,
  input  logic [IMG_W_BITS-1:0] w_out,
  input  logic [IMG_H_BITS-1:0] h_out,
  output logic [SRC_ADDR_W-1:0] src_addr,
  output logic [DST_ADDR_W-1:0] dst_addr,
  output logic                  last_in_block,
  output logic                  last_pixel
);

  localparam int BW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  logic [IMG_W_BITS-1:0] ox_q, ox_d;
  logic [IMG_H_BITS-1:0] oy_q, oy_d;
  logic [BW-1:0]         bx_q, bx_d, by_q, by_d;
  logic [DST_ADDR_W-1:0] pix_q, pix_d;
  logic [BW-1:0]         blk_max;
  logic                  last_col, last_row;
  logic [15:0]           sx, sy;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    blk_max  = '0;
    sx       = 16'(ox_q);
    sy       = 16'(oy_q);
    if (alg == ALG_AVERAGE) blk_max = BW'((32'd1 << k) - 32'd1);

    unique case (alg)
      ALG_REPLICATE: begin
        sx = 16'(ox_q) >> k;
        sy = 16'(oy_q) >> k;
      end
      ALG_DECIMATE: begin
        sx = 16'(ox_q) << k;
        sy = 16'(oy_q) << k;
      end
      ALG_AVERAGE: begin
        sx = (16'(ox_q) << k) + 16'(bx_q);
        sy = (16'(oy_q) << k) + 16'(by_q);
      end
      default: ;
    endcase

    last_col      = (ox_q == w_out - 10'd1);
    last_row      = (oy_q == h_out - 9'd1);
    last_in_block = (bx_q == blk_max) && (by_q == blk_max);
    last_pixel    = last_in_block && last_col && last_row;
    src_addr      = SRC_ADDR_W'(32'(sy) * SRC_W + 32'(sx));
    dst_addr      = pix_q;

    ox_d  = ox_q;
    oy_d  = oy_q;
    bx_d  = bx_q;
    by_d  = by_q;
    pix_d = pix_q;
    if (load) begin
      ox_d  = '0;
      oy_d  = '0;
      bx_d  = '0;
      by_d  = '0;
      pix_d = '0;
    end else if (step) begin
      // Block column fastest, then block row, then output pixel.
      if (bx_q != blk_max) begin
        bx_d = bx_q + BW'(1);
      end else begin
        bx_d = '0;
        if (by_q != blk_max) begin
          by_d = by_q + BW'(1);
        end else begin
          by_d  = '0;
          pix_d = (last_col && last_row) ? '0 : pix_q + DST_ADDR_W'(1);
          if (!last_col) begin
            ox_d = ox_q + 10'd1;
          end else begin
            ox_d = '0;
            oy_d = last_row ? '0 : oy_q + 9'd1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ox_q  <= '0;
      oy_q  <= '0;
      bx_q  <= '0;
      by_q  <= '0;
      pix_q <= '0;
    end else begin
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
      pix_q <= pix_d;
    end
  end

endmodule

// File: rtl/zoom_engine.sv
// Image scaling engine: reads the source ROM, applies replicate/decimate/average/copy at 2^k,
// and streams the result to the destination RAM with a two-cycle read-to-write pipeline.
module zoom_engine
  import coproc_pkg::*;
#(
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 120,
  parameter int PIX_W      = 8,
  parameter int SRC_ADDR_W = 15,
  parameter int DST_ADDR_W = 17,
  parameter int MAX_LOG2   = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [1:0]            ALGORITHM,
  input  logic [1:0]            ZOOM_LOG2,
  output logic [SRC_ADDR_W-1:0] SRC_ADDR,
  input  logic [PIX_W-1:0]      SRC_DATA,
  output logic [DST_ADDR_W-1:0] DST_ADDR,
  output logic [PIX_W-1:0]      DST_DATA,
  output logic                  DST_WREN,
  output logic [9:0]            IMG_WIDTH_OUT,
  output logic [8:0]            IMG_HEIGHT_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int ACC_W = PIX_W + 2 * MAX_LOG2;

  state_e                state_q, state_d;
  alg_e                  alg_q, alg_d;
  logic [1:0]            k_q, k_d;
  logic [IMG_W_BITS-1:0] width_q, width_d;
  logic [IMG_H_BITS-1:0] height_q, height_d;
  logic                  err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic                  rd_valid_q, rd_valid_d, rd_lib_q, rd_lib_d, rd_last_q, rd_last_d;
  logic [DST_ADDR_W-1:0] rd_dst_q, rd_dst_d;
  logic [ACC_W-1:0]      acc_q, acc_d, sum;
  logic [DST_ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [PIX_W-1:0]      dst_data_q, dst_data_d;
  logic                  dst_wren_q, dst_wren_d;
  logic [2:0]            shift;

  alg_e                  req_alg;
  logic [1:0]            req_k;
  logic                  req_ok;
  int                    req_w, req_h;

  logic                  load, step, last_in_block, last_pixel;
  logic [DST_ADDR_W-1:0] gen_dst_addr;

  zoom_addr_gen #(
    .SRC_W      (SRC_W),
    .SRC_ADDR_W (SRC_ADDR_W),
    .DST_ADDR_W (DST_ADDR_W),
    .MAX_LOG2   (MAX_LOG2)
  ) u_addr_gen (
    .clk           (CLK),
    .reset         (RESET),
    .load          (load),
    .step          (step),
    .alg           (alg_q),
    .k             (k_q),
    .w_out         (width_q),
    .h_out         (height_q),
    .src_addr      (SRC_ADDR),
    .dst_addr      (gen_dst_addr),
    .last_in_block (last_in_block),
    .last_pixel    (last_pixel)
  );

  // Request decode: k=0 on a scaling algorithm degenerates to a copy rather than an error.
  always_comb begin
    req_alg = alg_e'(ALGORITHM);
    req_k   = ZOOM_LOG2;
    req_ok  = 1'b1;
    req_w   = SRC_W;
    req_h   = SRC_H;
    if (req_alg != ALG_COPY) begin
      if (int'(ZOOM_LOG2) > MAX_LOG2) req_ok = 1'b0;
      else if (ZOOM_LOG2 == 2'd0)     req_alg = ALG_COPY;
    end
    if (req_alg == ALG_COPY) req_k = 2'd0;
    unique case (req_alg)
      ALG_REPLICATE: begin
        req_w = SRC_W << ZOOM_LOG2;
        req_h = SRC_H << ZOOM_LOG2;
      end
      ALG_DECIMATE, ALG_AVERAGE: begin
        req_w = SRC_W >> ZOOM_LOG2;
        req_h = SRC_H >> ZOOM_LOG2;
        if ((req_w << ZOOM_LOG2) != SRC_W || (req_h << ZOOM_LOG2) != SRC_H) req_ok = 1'b0;
      end
      default: ;
    endcase
    // Dimensions that overflow the size ports are refused alongside the RAM capacity limit.
    if (longint'(req_w) * longint'(req_h) > (longint'(1) << DST_ADDR_W) ||
        req_w >= (1 << IMG_W_BITS) || req_h >= (1 << IMG_H_BITS)) req_ok = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    alg_d    = alg_q;
    k_d      = k_q;
    width_d  = width_q;
    height_d = height_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (req_ok) begin
            state_d  = ST_RUN;
            alg_d    = req_alg;
            k_d      = req_k;
            width_d  = IMG_W_BITS'(req_w);
            height_d = IMG_H_BITS'(req_h);
            err_d    = 1'b0;
            busy_d   = 1'b1;
            load     = 1'b1;
          end else begin
            state_d = ST_FINISH;
            err_d   = 1'b1;
          end
        end
      end
      ST_RUN:   if (last_pixel) state_d = ST_DRAIN;
      ST_DRAIN: if (rd_valid_q && rd_last_q) state_d = ST_FINISH;
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step = (state_q == ST_RUN);

  // Read metadata travels alongside the ROM latency; the accumulator closes a block on its last read.
  always_comb begin
    rd_valid_d = (state_q == ST_RUN);
    rd_lib_d   = last_in_block;
    rd_last_d  = last_pixel;
    rd_dst_d   = gen_dst_addr;
    shift      = (alg_q == ALG_AVERAGE) ? {k_q, 1'b0} : 3'd0;
    sum        = acc_q + ACC_W'(SRC_DATA);
    acc_d      = load ? '0 : acc_q;
    dst_wren_d = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    if (rd_valid_q) begin
      if (rd_lib_q) begin
        acc_d      = '0;
        dst_wren_d = 1'b1;
        dst_addr_d = rd_dst_q;
        dst_data_d = PIX_W'(sum >> shift);
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      alg_q      <= ALG_COPY;
      k_q        <= 2'd0;
      width_q    <= IMG_W_BITS'(SRC_W);
      height_q   <= IMG_H_BITS'(SRC_H);
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_lib_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_dst_q   <= '0;
      acc_q      <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alg_q      <= alg_d;
      k_q        <= k_d;
      width_q    <= width_d;
      height_q   <= height_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_lib_q   <= rd_lib_d;
      rd_last_q  <= rd_last_d;
      rd_dst_q   <= rd_dst_d;
      acc_q      <= acc_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_wren_q <= dst_wren_d;
    end
  end

  assign DST_ADDR       = dst_addr_q;
  assign DST_DATA       = dst_data_q;
  assign DST_WREN       = dst_wren_q;
  assign IMG_WIDTH_OUT  = width_q;
  assign IMG_HEIGHT_OUT = height_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR            = err_q;

endmodule

// File: tb/tb_zoom_engine.sv
// Self-checking bench for zoom_engine on a small 16x10 image: each request is predicted
// from the scaling rules with plain arithmetic and compared cycle by cycle.
module tb_zoom_engine;

  localparam int SRC_W      = 16;
  localparam int SRC_H      = 10;
  localparam int PIX_W      = 8;
  localparam int SRC_ADDR_W = 8;
  localparam int DST_ADDR_W = 10;
  localparam int MAX_LOG2   = 2;
  localparam int ROM_N      = SRC_W * SRC_H;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [1:0]            algorithm = 2'd0;
  logic [1:0]            zoom_log2 = 2'd0;
  logic [SRC_ADDR_W-1:0] src_addr;
  logic [PIX_W-1:0]      src_data;
  logic [DST_ADDR_W-1:0] dst_addr;
  logic [PIX_W-1:0]      dst_data;
  logic                  dst_wren;
  logic [9:0]            img_width_out;
  logic [8:0]            img_height_out;
  logic                  busy, done, err;

  logic [PIX_W-1:0] rom [ROM_N];

  int n_checks = 0;
  int n_errors = 0;
  int exp_rd[$];
  int exp_wd[$];
  int m_ok, m_w, m_h, m_blk;
  int cur_w = SRC_W;
  int cur_h = SRC_H;
  int first_data;

  zoom_engine #(
    .SRC_W (SRC_W), .SRC_H (SRC_H), .PIX_W (PIX_W),
    .SRC_ADDR_W (SRC_ADDR_W), .DST_ADDR_W (DST_ADDR_W), .MAX_LOG2 (MAX_LOG2)
  ) dut (
    .CLK (clk), .RESET (reset), .START (start), .ALGORITHM (algorithm), .ZOOM_LOG2 (zoom_log2),
    .SRC_ADDR (src_addr), .SRC_DATA (src_data), .DST_ADDR (dst_addr), .DST_DATA (dst_data),
    .DST_WREN (dst_wren), .IMG_WIDTH_OUT (img_width_out), .IMG_HEIGHT_OUT (img_height_out),
    .BUSY (busy), .DONE (done), .ERR (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_data <= rom[src_addr];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Predicts acceptance, output size, the read address stream and the written pixel values.
  task automatic model(input int alg, input int k);
    int s, eff, w, h, a, acc;
    exp_rd.delete();
    exp_wd.delete();
    eff  = alg;
    s    = 1 << k;
    m_ok = 1;
    if (alg != 3) begin
      if (k > MAX_LOG2) m_ok = 0;
      else if (k == 0)  eff = 3;
    end
    w = SRC_W;
    h = SRC_H;
    if (eff == 0) begin
      w = SRC_W * s;
      h = SRC_H * s;
    end else if (eff != 3) begin
      if (SRC_W % s != 0 || SRC_H % s != 0) m_ok = 0;
      w = SRC_W / s;
      h = SRC_H / s;
    end
    if (w * h > (1 << DST_ADDR_W)) m_ok = 0;
    m_blk = (eff == 2) ? s * s : 1;
    if (m_ok == 0) begin
      m_w = cur_w;
      m_h = cur_h;
      return;
    end
    m_w   = w;
    m_h   = h;
    cur_w = w;
    cur_h = h;
    for (int oy = 0; oy < h; oy++) begin
      for (int ox = 0; ox < w; ox++) begin
        if (eff == 2) begin
          acc = 0;
          for (int by = 0; by < s; by++) begin
            for (int bx = 0; bx < s; bx++) begin
              a = (oy * s + by) * SRC_W + ox * s + bx;
              exp_rd.push_back(a);
              acc += int'(rom[a]);
            end
          end
          exp_wd.push_back(acc / (s * s));
        end else begin
          if (eff == 0)      a = (oy / s) * SRC_W + ox / s;
          else if (eff == 1) a = (oy * s) * SRC_W + ox * s;
          else               a = oy * SRC_W + ox;
          exp_rd.push_back(a);
          exp_wd.push_back(int'(rom[a]));
        end
      end
    end
  endtask

  // Issues one request at a negedge and follows it to DONE; poke re-pulses START while busy.
  task automatic run_op(input int alg, input int k, input bit poke);
    int c, nw, bad_rd, bad_wr, done_c, busy1, limit, wc;
    string tag;
    tag = $sformatf("alg%0d_k%0d", alg, k);
    model(alg, k);
    limit  = exp_rd.size() + 20;
    nw     = 0;
    bad_rd = 0;
    bad_wr = 0;
    done_c = -1;
    busy1  = 0;
    first_data = -1;
    start     = 1'b1;
    algorithm = 2'(alg);
    zoom_log2 = 2'(k);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (done_c < 0 && c <= limit) begin
      if (c == 1) busy1 = int'(busy);
      if (c <= exp_rd.size() && int'(src_addr) != exp_rd[c-1]) bad_rd++;
      if (dst_wren) begin
        wc = (nw + 1) * m_blk + 2;
        if (nw >= exp_wd.size() || int'(dst_addr) != nw || int'(dst_data) != exp_wd[nw] || c != wc)
          bad_wr++;
        if (nw == 0) first_data = int'(dst_data);
        nw++;
      end
      if (done) begin
        done_c = c;
      end else begin
        start = 1'b0;
        if (poke && c == 4) begin
          start     = 1'b1;
          algorithm = 2'(alg ^ 1);
          zoom_log2 = 2'(k ^ 1);
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_c, m_ok != 0 ? exp_rd.size() + 3 : 2);
    check({tag, "_writes"}, nw, exp_wd.size());
    check({tag, "_bad_reads"}, bad_rd, 0);
    check({tag, "_bad_writes"}, bad_wr, 0);
    check({tag, "_busy_first"}, busy1, m_ok);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_err"}, err, m_ok == 0);
    check({tag, "_width"}, img_width_out, m_w);
    check({tag, "_height"}, img_height_out, m_h);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int extra;
    for (int i = 0; i < ROM_N; i++) rom[i] = PIX_W'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_src_addr", src_addr, 0);
    check("rst_dst_addr", dst_addr, 0);
    check("rst_dst_data", dst_data, 0);
    check("rst_wren", dst_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_width", img_width_out, SRC_W);
    check("rst_height", img_height_out, SRC_H);

    run_op(3, 2, 1'b1);   // copy, START re-pulsed while busy
    run_op(0, 1, 1'b0);   // replicate x2: 32x20
    run_op(0, 2, 1'b0);   // replicate x4 too large: rejected, dims stay 32x20
    rom[0] = 8'd10; rom[1] = 8'd20; rom[SRC_W] = 8'd30; rom[SRC_W+1] = 8'd41;
    run_op(2, 1, 1'b0);   // average 2x2
    check("avg_block0", first_data, 25);
    run_op(1, 1, 1'b0);   // decimate: 8x5
    run_op(1, 2, 1'b0);   // 10 rows not divisible by 4: rejected
    run_op(2, 3, 1'b0);   // k above MAX_LOG2: rejected
    run_op(0, 0, 1'b0);   // k=0 treated as copy
    for (int i = 0; i < 6; i++) run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);

    // Reset in the middle of a replicate run, with START held high alongside it.
    start = 1'b1; algorithm = 2'd0; zoom_log2 = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midrst_wren", dst_wren, 0);
    check("midrst_busy", busy, 0);
    check("midrst_src_addr", src_addr, 0);
    check("midrst_dst_addr", dst_addr, 0);
    check("midrst_dst_data", dst_data, 0);
    check("midrst_width", img_width_out, SRC_W);
    check("midrst_height", img_height_out, SRC_H);
    reset = 1'b0;
    start = 1'b0;
    cur_w = SRC_W;
    cur_h = SRC_H;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (dst_wren || busy || done) extra++;
    end
    check("midrst_idle_after", extra, 0);
    run_op(3, 0, 1'b0);   // engine recovers after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zoom_engine.md
# zoom_engine

Parametrised image-scaling engine for the coprocessor: on a start pulse it reads a source image from the initial-image ROM, applies one of four scaling algorithms at a selectable power-of-two factor, and streams the result into the processing RAM that feeds the VGA path. It is the generalised successor to the fixed-size, fixed-factor data-processing block. Source/destination geometry, pixel width and factor range are parameters. It reports the output dimensions to the VGA controller.

## Interface
- SRC_W, 160: source image width in pixels
- SRC_H, 120: source image height in pixels
- PIX_W, 8: pixel width in bits
- SRC_ADDR_W, 15: source ROM address width
- DST_ADDR_W, 17: destination RAM address width; output image must fit in 2^DST_ADDR_W pixels
- MAX_LOG2, 2: largest supported zoom exponent (factor 2^MAX_LOG2)

- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle start request
- ALGORITHM  in  2  0 replicate-up, 1 decimate-down, 2 block-average-down, 3 copy
- ZOOM_LOG2  in  2  zoom exponent k (factor 2^k); ignored for copy
- SRC_ADDR  out  SRC_ADDR_W  ROM read address
- SRC_DATA  in  PIX_W  ROM data, valid exactly one cycle after SRC_ADDR
- DST_ADDR  out  DST_ADDR_W  RAM write address
- DST_DATA  out  PIX_W  RAM write data
- DST_WREN  out  1  RAM write enable
- IMG_WIDTH_OUT  out  10  output image width
- IMG_HEIGHT_OUT  out  9  output image height
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  last request rejected

## Operation
- States: IDLE, RUN, DRAIN, FINISH. START sampled only in IDLE; ignored otherwise.
- On START in IDLE: ALGORITHM and ZOOM_LOG2 latched; output size computed and validated.
- Output size: replicate SRC_W<<k × SRC_H<<k; decimate/average SRC_W>>k × SRC_H>>k; copy SRC_W × SRC_H.
- Rejected if k > MAX_LOG2, if k=0 with algorithms 0–2 (treated as copy instead — not rejected), if a down-scale does not divide SRC_W/SRC_H exactly, or if output pixel count > 2^DST_ADDR_W. Rejected: no writes, IDLE→FINISH, ERR=1, dims unchanged.
- Accepted: ERR cleared, IMG_WIDTH_OUT/HEIGHT_OUT updated, IDLE→RUN.
- Output pixels raster order; DST_ADDR = oy*W_out + ox, starting at 0.
- Replicate: source (ox>>k, oy>>k). Decimate: source (ox<<k, oy<<k). Copy: source = output coord.
- Average: per output pixel, reads the 2^k×2^k block row-major; accumulator PIX_W+2·MAX_LOG2 bits; result = sum>>2k (truncate).
- SRC_ADDR = sy*SRC_W + sx.
- RUN→DRAIN after last read issued; DRAIN→FINISH after last write; FINISH→IDLE after one cycle (DONE pulse).

## Timing
- Reset values: SRC_ADDR=0, DST_ADDR=0, DST_DATA=0, DST_WREN=0, BUSY=0, DONE=0, ERR=0, IMG_WIDTH_OUT=SRC_W, IMG_HEIGHT_OUT=SRC_H; state IDLE.
- START at edge e → BUSY=1 and first SRC_ADDR after e; for rejected requests, DONE after e+1.
- Read issued cycle t → SRC_DATA in t+1 → registered write (DST_WREN=1) in t+2.
- Replicate/decimate/copy: one read and one write per cycle; N output pixels → writes in N consecutive cycles; DONE one cycle after last write; BUSY falls with DONE.
- Average: 4^k reads per output pixel back-to-back; one write per block, two cycles after the block's last read.
- RESET mid-operation: next edge returns all outputs to reset values; no further writes.

## Structure
- Shared package coproc_pkg: algorithm codes (ALG_REPLICATE, ALG_DECIMATE, ALG_AVERAGE, ALG_COPY), state encoding.
- Sub-module zoom_addr_gen: nested output/block counters producing source coordinates, SRC_ADDR, DST_ADDR, last-in-block and last-pixel flags.

## Test plan
- Copy, defaults: START → 19200 writes at DST_ADDR 0..19199, DST_DATA equal to ROM[same addr], DONE pulse on the cycle after the last write.
- Replicate k=1: dims 320×240; DST_ADDR 0,1 and 320,321 all equal ROM[0]; 76800 writes.
- Replicate k=2: 640×480 exceeds 2^17 → no DST_WREN, DONE after 2 cycles, ERR=1, dims stay 160×120.
- Average k=1 on ROM block {10,20,30,41} → DST_DATA[0]=25; 4 reads per write.
- Decimate k=2: 40×30; DST_ADDR 1 reads SRC_ADDR 4, DST_ADDR 40 reads SRC_ADDR 640.
- RESET asserted mid-RUN, START pulsed while BUSY: WREN low next edge, state IDLE; START while BUSY has no effect.
